wb_target_mem: RTL and testbench
================================

// Module: wb_target_mem
// PURPOSE
//  Wishbone classic-cycle target (responder) backed by a word-wide memory. Sits on one target
//  port of the NxN interconnect (tadr/tdat_w/tcyc/... fan into it). Registered ack/err with
//  programmable wait states, byte-lane writes, out-of-range detection, and a single
//  outstanding transfer. Serves as both scratch RAM and the standard responder model for
//  interconnect benches.
// PARAMETERS
//  WB_ADDR_WIDTH  32   address width, byte addressed
//  WB_DATA_WIDTH  32   data width; multiple of 8
//  MEM_WORDS      256  memory depth in words; power of 2
//  WAIT_STATES    1    extra cycles between request sample and response (0..15)
//  OFFSET_WIDTH   24   low address bits forming the in-region byte offset
// PORTS
//  clock   in   1                 clock, all logic on rising edge
//  reset   in   1                 asynchronous, active-low reset (0 = reset asserted)
//  adr     in   WB_ADDR_WIDTH     byte address
//  dat_w   in   WB_DATA_WIDTH     write data
//  dat_r   out  WB_DATA_WIDTH     read data, valid while ack=1
//  cyc     in   1                 bus cycle active
//  stb     in   1                 strobe
//  we      in   1                 1 = write
//  sel     in   WB_DATA_WIDTH/8   byte enables
//  ack     out  1                 transfer acknowledge, single-cycle pulse
//  err     out  1                 transfer error, single-cycle pulse
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE, ack=0, err=0, dat_r=0, wait counter=0. Memory is not cleared.
//  - ADDR_LSB=$clog2(WB_DATA_WIDTH/8); word index = adr[ADDR_LSB+:$clog2(MEM_WORDS)].
//    Out of range when adr[OFFSET_WIDTH-1:ADDR_LSB] >= MEM_WORDS. Bits above OFFSET_WIDTH ignored.
//  - FSM states: IDLE, WAIT, RESP.
//    IDLE: on cyc&stb at a rising edge, capture adr/dat_w/we/sel/range flag; counter=WAIT_STATES;
//          next = (WAIT_STATES==0) ? RESP : WAIT.
//    WAIT: counter decrements each cycle; if cyc==0 -> IDLE (abort: no write, no ack/err);
//          at counter==1 with cyc&stb -> RESP.
//    RESP: ack or err high for exactly this one cycle; -> IDLE unconditionally.
//  - Entry into RESP (same edge that raises ack/err) performs the access on captured fields:
//    write: byte lane b updated iff sel[b]; read: dat_r = full word, sel ignored.
//  - Latency: request sampled at edge k -> ack/err high during cycle k+1+WAIT_STATES.
//  - Throughput: RESP always followed by >=1 IDLE cycle; max one transfer per WAIT_STATES+2 cycles.
//  - ack and err are never high together; ack/err/dat_r are flop outputs; dat_r returns to 0 in IDLE/WAIT.
//  - Fields changing during WAIT are a protocol violation; captured values are used.
//  - cyc=1,stb=0 in IDLE: no action. Reset mid-WAIT/RESP: immediate return to IDLE, pending write dropped.
// CONFIGURATION
//  WB_TARGET_MEM_ERR_EN defined: out-of-range transfer -> err pulse (ack=0), no memory write,
//    dat_r=0.
//  WB_TARGET_MEM_ERR_EN undefined: err tied 0; out-of-range -> normal ack with dat_r=0,
//    write dropped.
//  Timing identical in both builds.
// TESTING (defaults unless noted)
//  1 write adr=0x10 dat_w=0xDEADBEEF sel=0xF, then read adr=0x10 -> each ack in cycle k+2,
//    read dat_r=0xDEADBEEF, err=0.
//  2 write adr=0x10 sel=0x2 dat_w=0x00005500, read adr=0x10 -> dat_r=0xDEAD55EF.
//  3 write adr=0x400 (word 256): ERR_EN -> err 1 cycle, ack 0; no ERR_EN -> ack, dat_r=0;
//    adr=0x0 word unchanged.
//  4 read adr=0x10 sampled, cyc dropped next cycle -> no ack/err; abort a write likewise ->
//    word unchanged on readback.
//  5 reset=0 during WAIT -> ack/err/dat_r=0 without clock edge; after release, next write/read
//    completes normally.
//  6 WAIT_STATES=0, back-to-back reads holding cyc=1 -> ack in cycle k+1, one ack every 2 cycles,
//    correct data each.

Source files
------------

// File: rtl/wb_target_mem.sv
// -----------------------------------------------------------------------------
// wb_target_mem
//
// Purpose:
//   Wishbone classic-cycle responder with a word-wide memory behind it. It
//   accepts one transfer at a time and answers with a registered ack or err
//   after a fixed number of wait states. Writes honour the byte enables.
//   Addresses outside the memory region are detected and never reach the
//   memory. It serves as scratch RAM and as the standard responder model on
//   interconnect target ports.
//
// Optional build macro:
//   WB_TARGET_MEM_ERR_EN - when defined, an out-of-range transfer ends with an
//                          err pulse instead of an ack. When undefined, err is
//                          held at 0 and an out-of-range transfer is acked with
//                          dat_r = 0. The write is dropped and the timing is
//                          the same in both builds.
//
// Ports:
//   clock  in   1              clock, rising edge
//   reset  in   1              asynchronous reset, active low
//   adr    in   WB_ADDR_WIDTH  byte address
//   dat_w  in   WB_DATA_WIDTH  write data
//   dat_r  out  WB_DATA_WIDTH  read data, valid while ack = 1, 0 otherwise
//   cyc    in   1              bus cycle active
//   stb    in   1              strobe
//   we     in   1              1 = write
//   sel    in   WB_DATA_WIDTH/8 byte enables
//   ack    out  1              acknowledge, single-cycle pulse
//   err    out  1              error, single-cycle pulse
// -----------------------------------------------------------------------------
module wb_target_mem #(
   parameter int WB_ADDR_WIDTH = 32,
   parameter int WB_DATA_WIDTH = 32,
   parameter int MEM_WORDS     = 256,
   parameter int WAIT_STATES   = 1,
   parameter int OFFSET_WIDTH  = 24
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WB_ADDR_WIDTH-1:0]   adr,
   input  logic [WB_DATA_WIDTH-1:0]   dat_w,
   output logic [WB_DATA_WIDTH-1:0]   dat_r,
   input  logic                       cyc,
   input  logic                       stb,
   input  logic                       we,
   input  logic [WB_DATA_WIDTH/8-1:0] sel,
   output logic                       ack,
   output logic                       err
);

   localparam int         SEL_W    = WB_DATA_WIDTH / 8;
   localparam int         ADDR_LSB = $clog2(SEL_W);
   localparam int         IDX_W    = $clog2(MEM_WORDS);
   localparam logic [3:0] WS_INIT  = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                    state_q, state_d;
   logic [3:0]                cnt_q, cnt_d;
   logic                      ack_q, ack_d;
   logic                      err_q, err_d;
   logic [WB_DATA_WIDTH-1:0]  dat_r_q, dat_r_d;

   // Fields captured when the request is sampled in IDLE
   logic [IDX_W-1:0]          idx_q;
   logic                      oor_q;
   logic                      we_q;
   logic [SEL_W-1:0]          sel_q;
   logic [WB_DATA_WIDTH-1:0]  dat_w_q;

   logic [WB_DATA_WIDTH-1:0]  mem_q [MEM_WORDS];

   logic                      req;
   logic [IDX_W-1:0]          live_idx;
   logic                      live_oor;
   logic                      go_resp;
   logic                      mem_we;

   logic [IDX_W-1:0]          acc_idx;
   logic                      acc_oor;
   logic                      acc_we;
   logic [SEL_W-1:0]          acc_sel;
   logic [WB_DATA_WIDTH-1:0]  acc_dat_w;

   // Only a slice of adr is decoded; the rest is ignored on purpose.
   logic                      unused_adr;
   assign unused_adr = ^adr;

   assign req      = cyc & stb;
   assign live_idx = adr[ADDR_LSB +: IDX_W];
   // Word offset >= MEM_WORDS is the same as any offset bit above the index being set.
   assign live_oor = |adr[OFFSET_WIDTH-1 : ADDR_LSB+IDX_W];

   // With zero wait states the access happens on the same edge that samples
   // the request, so the live bus fields are used; otherwise the captured ones.
   assign acc_idx   = (state_q == S_IDLE) ? live_idx : idx_q;
   assign acc_oor   = (state_q == S_IDLE) ? live_oor : oor_q;
   assign acc_we    = (state_q == S_IDLE) ? we       : we_q;
   assign acc_sel   = (state_q == S_IDLE) ? sel      : sel_q;
   assign acc_dat_w = (state_q == S_IDLE) ? dat_w    : dat_w_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_r_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_r_q <= dat_r_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      go_resp = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_r_d = '0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               cnt_d = WS_INIT;
               if (WS_INIT == 4'd0) begin
                  state_d = S_RESP;
                  go_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!cyc) begin
               // Master abandoned the cycle: drop the transfer silently.
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd1) begin
               // Hold at the last wait count until the strobe is present.
               if (stb) begin
                  state_d = S_RESP;
                  cnt_d   = 4'd0;
                  go_resp = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      if (go_resp) begin
`ifdef WB_TARGET_MEM_ERR_EN
         ack_d = ~acc_oor;
         err_d = acc_oor;
`else
         ack_d = 1'b1;
`endif
         if (!acc_we && !acc_oor) begin
            dat_r_d = mem_q[acc_idx];
         end
      end
   end

   // Gated with reset so a zero-wait request seen while reset is held cannot write.
   assign mem_we = go_resp & acc_we & ~acc_oor & reset;

   always_ff @(posedge clock) begin
      if (state_q == S_IDLE && req) begin
         idx_q   <= live_idx;
         oor_q   <= live_oor;
         we_q    <= we;
         sel_q   <= sel;
         dat_w_q <= dat_w;
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < SEL_W; b++) begin
            if (acc_sel[b]) begin
               mem_q[acc_idx][8*b +: 8] <= acc_dat_w[8*b +: 8];
            end
         end
      end
   end

   assign ack   = ack_q;
   assign err   = err_q;
   assign dat_r = dat_r_q;

endmodule

// File: tb/tb_wb_target_mem.sv
// -----------------------------------------------------------------------------
// tb_wb_target_mem
//
// Two responders share the clock and reset: instance 0 uses one wait state,
// instance 1 uses zero wait states. A per-instance array model holds the
// expected memory contents; expected responses are derived from the address
// decode rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_wb_target_mem;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0][31:0] adr;
   logic [1:0][31:0] dat_w;
   wire  [1:0][31:0] dat_r;
   logic [1:0]       cyc;
   logic [1:0]       stb;
   logic [1:0]       we;
   logic [1:0][3:0]  sel;
   wire  [1:0]       ack;
   wire  [1:0]       err;

   always #5 clk = ~clk;

   wb_target_mem #(.WAIT_STATES(1)) u_dut0 (
      .clock(clk), .reset(rst_n), .adr(adr[0]), .dat_w(dat_w[0]), .dat_r(dat_r[0]),
      .cyc(cyc[0]), .stb(stb[0]), .we(we[0]), .sel(sel[0]), .ack(ack[0]), .err(err[0])
   );

   wb_target_mem #(.WAIT_STATES(0)) u_dut1 (
      .clock(clk), .reset(rst_n), .adr(adr[1]), .dat_w(dat_w[1]), .dat_r(dat_r[1]),
      .cyc(cyc[1]), .stb(stb[1]), .we(we[1]), .sel(sel[1]), .ack(ack[1]), .err(err[1])
   );

   logic [31:0] mdl [2][256];
   int          n_chk = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int ws(input int i);
      return (i == 0) ? 1 : 0;
   endfunction

   function automatic bit is_oor(input logic [31:0] a);
      return ((a & 32'h00FF_FFFF) >> 2) >= 256;
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'(((a & 32'h00FF_FFFF) >> 2) % 256);
   endfunction

   // One complete transfer with latency, response, data and pulse-width checks.
   task automatic xfer(input int i, input logic [31:0] a, input logic [31:0] d,
                       input bit w, input logic [3:0] s);
      bit          oor;
      int          idx;
      int          n;
      logic        e_ack, e_err;
      logic [31:0] e_dat;
      oor = is_oor(a);
      idx = word_of(a);
`ifdef WB_TARGET_MEM_ERR_EN
      e_ack = ~oor;
      e_err = oor;
`else
      e_ack = 1'b1;
      e_err = 1'b0;
`endif
      e_dat = oor ? 32'h0 : mdl[i][idx];

      @(posedge clk); #1;
      adr[i] = a; dat_w[i] = d; we[i] = w; sel[i] = s;
      cyc[i] = 1'b1; stb[i] = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (!(ack[i] | err[i]) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("latency[%0d]", i), n, ws(i));
      chk($sformatf("ack[%0d]", i), {31'b0, ack[i]}, {31'b0, e_ack});
      chk($sformatf("err[%0d]", i), {31'b0, err[i]}, {31'b0, e_err});
      if (!w) chk($sformatf("rdata[%0d] a=%h", i, a), dat_r[i], e_dat);
      cyc[i] = 1'b0; stb[i] = 1'b0;
      if (w && !oor) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) mdl[i][idx][8*b +: 8] = d[8*b +: 8];
         end
      end
      @(posedge clk); #1;
      chk($sformatf("pulse[%0d]", i), {30'b0, ack[i], err[i]}, 32'h0);
      chk($sformatf("dat_idle[%0d]", i), dat_r[i], 32'h0);
   endtask

   // Request sampled, then cyc dropped during the wait state.
   task automatic abort_xfer(input logic [31:0] a, input logic [31:0] d, input bit w);
      @(posedge clk); #1;
      adr[0] = a; dat_w[0] = d; we[0] = w; sel[0] = 4'hF;
      cyc[0] = 1'b1; stb[0] = 1'b1;
      @(posedge clk); #1;
      cyc[0] = 1'b0; stb[0] = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_no_resp", {30'b0, ack[0], err[0]}, 32'h0);
      end
   endtask

   initial begin
      logic [31:0] a;
      int          inst;
      int          wd;
      rst_n = 1'b0;
      adr = '0; dat_w = '0; cyc = '0; stb = '0; we = '0; sel = '0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_ack[%0d]", i), {31'b0, ack[i]}, 32'h0);
         chk($sformatf("rst_err[%0d]", i), {31'b0, err[i]}, 32'h0);
         chk($sformatf("rst_dat[%0d]", i), dat_r[i], 32'h0);
      end
      #21 rst_n = 1'b1;

      // Give the words used below defined contents.
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 32; k++)
            xfer(i, 32'(k * 4), $urandom, 1'b1, 4'hF);

      // Full write then readback; byte-lane write then readback.
      xfer(0, 32'h10, 32'hDEAD_BEEF, 1'b1, 4'hF);
      xfer(0, 32'h10, 32'h0, 1'b0, 4'hF);
      xfer(0, 32'h10, 32'h0000_5500, 1'b1, 4'h2);
      xfer(0, 32'h10, 32'h0, 1'b0, 4'hF);
      chk("byte_lane_model", mdl[0][4], 32'hDEAD_55EF);

      // Out-of-range write must not alias onto word 0.
      xfer(0, 32'h400, 32'h1234_5678, 1'b1, 4'hF);
      xfer(0, 32'h0, 32'h0, 1'b0, 4'hF);
      xfer(0, 32'h400, 32'h0, 1'b0, 4'hF);
      xfer(0, 32'hAB00_0014, 32'h0, 1'b0, 4'hF);

      // Aborted read, aborted write, then readback.
      abort_xfer(32'h10, 32'h0, 1'b0);
      abort_xfer(32'h10, 32'hFFFF_FFFF, 1'b1);
      xfer(0, 32'h10, 32'h0, 1'b0, 4'hF);

      // Reset during the wait state drops the pending write.
      @(posedge clk); #1;
      adr[0] = 32'h14; dat_w[0] = 32'hCAFE_F00D; we[0] = 1'b1; sel[0] = 4'hF;
      cyc[0] = 1'b1; stb[0] = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_wait_ack", {31'b0, ack[0]}, 32'h0);
      chk("rst_wait_dat", dat_r[0], 32'h0);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(posedge clk); #3 rst_n = 1'b1;
      xfer(0, 32'h14, 32'h0, 1'b0, 4'hF);

      // Reset while ack is high clears the outputs without a clock edge.
      @(posedge clk); #1;
      adr[0] = 32'h10; we[0] = 1'b0; sel[0] = 4'hF; cyc[0] = 1'b1; stb[0] = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("resp_ack", {31'b0, ack[0]}, 32'h1);
      chk("resp_dat", dat_r[0], mdl[0][4]);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_resp_ack", {31'b0, ack[0]}, 32'h0);
      chk("rst_resp_dat", dat_r[0], 32'h0);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(posedge clk); #3 rst_n = 1'b1;
      xfer(0, 32'h18, 32'h0BAD_F00D, 1'b1, 4'hF);
      xfer(0, 32'h18, 32'h0, 1'b0, 4'hF);

      // Zero wait states, cyc held: one ack every other cycle.
      @(posedge clk); #1;
      adr[1] = 32'h0; we[1] = 1'b0; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(posedge clk); #1;
         chk($sformatf("b2b_ack%0d", j), {31'b0, ack[1]}, 32'h1);
         chk($sformatf("b2b_dat%0d", j), dat_r[1], mdl[1][j]);
         if (j == 5) begin
            cyc[1] = 1'b0; stb[1] = 1'b0;
         end else begin
            adr[1] = 32'((j + 1) * 4);
         end
         @(posedge clk); #1;
         chk($sformatf("b2b_gap%0d", j), {31'b0, ack[1]}, 32'h0);
      end

      // Randomized traffic on both instances.
      for (int t = 0; t < 120; t++) begin
         inst = $urandom_range(0, 1);
         wd   = $urandom_range(0, 31);
         a    = (32'($urandom_range(0, 255)) << 24) | (32'(wd) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 16383)) << 10);
         xfer(inst, a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
